// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage sequencing controller (load-use stall,
// execute hold, redirect flush) driven by one priority FSM.
// Ports: clk, rst_n (async, active-low); id_* incoming decode fields;
//   de_* decode-register instruction; ex_busy, br_taken, br_target from
//   execute; stall_fetch, stall_de, bubble_de, redirect_valid,
//   redirect_pc, state outputs (Mealy, forced 0 while rst_n low).
// Optional: define HAZARD_STATS_EN to add saturating stall_cycles and
//   flush_cycles counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        de_valid,
    input  logic [4:0]  de_rd,
    input  logic        de_is_load,
    input  logic        ex_busy,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        stall_fetch,
    output logic        stall_de,
    output logic        bubble_de,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        EX_WAIT  = 2'd3
    } state_t;

    // The detection cycle is the first stall cycle, so LU_STALL only
    // covers the remaining LOAD_LAT-1 cycles (none when LOAD_LAT==1).
    localparam logic [2:0] LU_INIT = 3'((LOAD_LAT >= 2) ? LOAD_LAT - 2 : 0);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic       LU_MULTI = (LOAD_LAT >= 2);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        lu;
    logic        sf, sd, bd, rv;
    logic [31:0] rpc;

    assign lu = de_valid & de_is_load & (de_rd != 5'd0) & id_valid &
                ((id_uses_rs1 & (id_rs1 == de_rd)) |
                 (id_uses_rs2 & (id_rs2 == de_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sf      = 1'b0;
        sd      = 1'b0;
        bd      = 1'b0;
        rv      = 1'b0;
        rpc     = 32'd0;
        if (br_taken) begin
            rv      = 1'b1;
            rpc     = br_target;
            bd      = 1'b1;
            state_d = FLUSH;
            cnt_d   = FL_INIT;
        end else if (ex_busy) begin
            // hold in place; any load-use countdown is dropped
            sf      = 1'b1;
            sd      = 1'b1;
            state_d = EX_WAIT;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                LU_STALL: begin
                    sf = 1'b1;
                    sd = 1'b1;
                    bd = 1'b1;
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                FLUSH: begin
                    bd = 1'b1;
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                default: begin
                    // RUN, and EX_WAIT once execute releases
                    state_d = RUN;
                    if (lu) begin
                        sf = 1'b1;
                        sd = 1'b1;
                        bd = 1'b1;
                        if (LU_MULTI) begin
                            state_d = LU_STALL;
                            cnt_d   = LU_INIT;
                        end
                    end
                end
            endcase
        end
    end

    assign stall_fetch    = rst_n & sf;
    assign stall_de       = rst_n & sd;
    assign bubble_de      = rst_n & bd;
    assign redirect_valid = rst_n & rv;
    assign redirect_pc    = rst_n ? rpc : 32'd0;
    assign state          = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_de && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bubble_de && !stall_de && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`endif

endmodule
